// File: rtl/dacrdbk_pkg.sv
// Shared AD5791 serial-link constants and the readback controller state type.
package dacrdbk_pkg;

  localparam int DAC_DATA_NBIT     = 20;
  localparam int DAC_CMD_NBIT      = 3;
  localparam int DAC_FRAME_NBIT    = 24;
  localparam int DAC_SCLK_DIV      = 10;
  localparam int DAC_SCLK_DIV_NBIT = 4;

  localparam logic                    DAC_RW_READ   = 1'b1;
  localparam logic [DAC_CMD_NBIT-1:0] DAC_CMD_RG    = 3'b001;
  localparam logic [DAC_CMD_NBIT-1:0] DAC_CMD_CTRL  = 3'b010;
  localparam logic [DAC_CMD_NBIT-1:0] DAC_CMD_CLR   = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_GAP  = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

endpackage

// File: rtl/dac_sclk_gen.sv
// Free-running bit-period divider: frame tick, late-low sdin sample strobe and gated sclk.
module dac_sclk_gen
  import dacrdbk_pkg::*;
#(
  parameter int SCLK_DIV = DAC_SCLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_gate,
  output logic o_tick,
  output logic o_sample,
  output logic o_sclk
);

  localparam int DIV_NBIT = $clog2(SCLK_DIV);
  localparam logic [DIV_NBIT-1:0] C_LAST = DIV_NBIT'(SCLK_DIV - 1);
  localparam logic [DIV_NBIT-1:0] C_SAMP = DIV_NBIT'(SCLK_DIV - 2);
  localparam logic [DIV_NBIT-1:0] C_HALF = DIV_NBIT'(SCLK_DIV / 2);
  localparam logic [DIV_NBIT-1:0] C_ONE  = DIV_NBIT'(1);

  logic [DIV_NBIT-1:0] r_div_cnt;

  // i_clr realigns the phase so the next frame starts on a full period
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (i_clr || (r_div_cnt == C_LAST)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + C_ONE;
    end
  end

  assign o_tick   = (r_div_cnt == C_LAST);
  assign o_sample = (r_div_cnt == C_SAMP);
  assign o_sclk   = ~i_gate | (r_div_cnt < C_HALF);

endmodule

// File: rtl/dacrdbk.sv
// AD5791 register readback: read-command frame, gap, then NOP frame while shifting sdin in.
module dacrdbk
  import dacrdbk_pkg::*;
#(
  parameter int DATA_NBIT = DAC_DATA_NBIT,
  parameter int CMD_NBIT  = DAC_CMD_NBIT,
  parameter int SCLK_DIV  = DAC_SCLK_DIV
) (
  input  logic                 i_mclk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_rd_req,
  input  logic [CMD_NBIT-1:0]  i_rd_addr,
  output logic                 o_rd_busy,
  output logic                 o_rx_dv,
  output logic [CMD_NBIT-1:0]  o_rx_addr,
  output logic [DATA_NBIT-1:0] o_rx_data,
  output logic                 o_rx_err,
  output logic                 o_sclk,
  output logic                 o_sdo,
  input  logic                 i_sdin,
  output logic                 o_sync
);

  localparam int FRAME_NBIT = 1 + CMD_NBIT + DATA_NBIT;
  localparam logic [4:0] C_BIT_LAST = 5'(FRAME_NBIT - 1);
  localparam logic [4:0] C_BIT_ZERO = 5'd0;
  localparam logic [4:0] C_BIT_ONE  = 5'd1;

  rd_state_e             r_state, w_state;
  logic [4:0]            r_bit_cnt, w_bit_cnt;
  logic [FRAME_NBIT-1:0] r_tx, w_tx, r_rx, w_rx, w_frame;
  logic [CMD_NBIT-1:0]   r_addr, w_addr, r_pend_addr, w_pend_addr, w_req_addr;
  logic [CMD_NBIT-1:0]   r_rx_addr, w_rx_addr;
  logic [DATA_NBIT-1:0]  r_rx_data, w_rx_data;
  logic r_pend, w_pend, r_sync, w_sync, r_sdo, w_sdo, r_busy, w_busy;
  logic r_dv, w_dv, r_rx_err, w_rx_err;
  logic w_tick, w_sample, w_clr, w_req;

  dac_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .i_clk    (i_mclk),
    .i_rst    (i_rst),
    .i_clr    (w_clr),
    .i_gate   (r_sync),
    .o_tick   (w_tick),
    .o_sample (w_sample),
    .o_sclk   (o_sclk)
  );

  // A request pulse landing mid-period is remembered until the next tick
  assign w_req      = i_en & (i_rd_req | r_pend);
  assign w_req_addr = i_rd_req ? i_rd_addr : r_pend_addr;
  assign w_frame    = {DAC_RW_READ, w_req_addr, {DATA_NBIT{1'b0}}};
  assign w_clr      = (r_state == ST_DONE);

  // Next-state and datapath: frame boundaries only on tick, DONE lasts one mclk
  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_tx        = r_tx;
    w_addr      = r_addr;
    w_pend      = r_pend;
    w_pend_addr = r_pend_addr;
    w_sync      = r_sync;
    w_sdo       = r_sdo;
    w_busy      = r_busy;
    w_dv        = 1'b0;
    w_rx_data   = r_rx_data;
    w_rx_addr   = r_rx_addr;
    w_rx_err    = r_rx_err;
    if ((r_state == ST_READ) && w_sample) begin
      w_rx = {r_rx[FRAME_NBIT-2:0], i_sdin};
    end else begin
      w_rx = r_rx;
    end

    case (r_state)
      ST_IDLE: begin
        if (!i_en) begin
          w_pend = 1'b0;
        end else if (i_rd_req) begin
          w_pend      = 1'b1;
          w_pend_addr = i_rd_addr;
        end else begin
          w_pend = r_pend;
        end
        if (w_tick && w_req) begin
          w_state   = ST_CMD;
          w_addr    = w_req_addr;
          w_sdo     = w_frame[FRAME_NBIT-1];
          w_tx      = {w_frame[FRAME_NBIT-2:0], 1'b0};
          w_bit_cnt = C_BIT_LAST;
          w_sync    = 1'b1;
          w_busy    = 1'b1;
          w_pend    = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_tick && (r_bit_cnt == C_BIT_ZERO)) begin
          w_sync = 1'b0;
          w_sdo  = 1'b0;
          if (i_en) begin
            w_state = ST_GAP;
          end else begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
          end
        end else if (w_tick) begin
          w_bit_cnt = r_bit_cnt - C_BIT_ONE;
          w_sdo     = r_tx[FRAME_NBIT-1];
          w_tx      = {r_tx[FRAME_NBIT-2:0], 1'b0};
        end else begin
          w_state = ST_CMD;
        end
      end
      ST_GAP: begin
        if (w_tick && i_en) begin
          w_state   = ST_READ;
          w_sync    = 1'b1;
          w_sdo     = 1'b0;
          w_bit_cnt = C_BIT_LAST;
          w_rx      = '0;
        end else if (w_tick) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
        end else begin
          w_state = ST_GAP;
        end
      end
      ST_READ: begin
        if (w_tick && (r_bit_cnt == C_BIT_ZERO)) begin
          w_sync = 1'b0;
          if (i_en) begin
            w_state   = ST_DONE;
            w_dv      = 1'b1;
            w_rx_data = r_rx[DATA_NBIT-1:0];
            w_rx_addr = r_rx[DATA_NBIT +: CMD_NBIT];
            w_rx_err  = (r_rx[FRAME_NBIT-1] != DAC_RW_READ) ||
                        (r_rx[DATA_NBIT +: CMD_NBIT] != r_addr);
          end else begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
          end
        end else if (w_tick) begin
          w_bit_cnt = r_bit_cnt - C_BIT_ONE;
        end else begin
          w_state = ST_READ;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = ST_IDLE;
        w_sync  = 1'b0;
        w_sdo   = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame at once
  always_ff @(posedge i_mclk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_addr      <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_sync      <= 1'b0;
      r_sdo       <= 1'b0;
      r_busy      <= 1'b0;
      r_dv        <= 1'b0;
      r_rx_data   <= '0;
      r_rx_addr   <= '0;
      r_rx_err    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_addr      <= w_addr;
      r_pend      <= w_pend;
      r_pend_addr <= w_pend_addr;
      r_sync      <= w_sync;
      r_sdo       <= w_sdo;
      r_busy      <= w_busy;
      r_dv        <= w_dv;
      r_rx_data   <= w_rx_data;
      r_rx_addr   <= w_rx_addr;
      r_rx_err    <= w_rx_err;
    end
  end

  assign o_rd_busy = r_busy;
  assign o_rx_dv   = r_dv;
  assign o_rx_addr = r_rx_addr;
  assign o_rx_data = r_rx_data;
  assign o_rx_err  = r_rx_err;
  assign o_sdo     = r_sdo;
  assign o_sync    = r_sync;

endmodule

// File: tb/tb_dacrdbk.sv
// Directed bench for dacrdbk with a behavioural AD5791 readback model on sdin.
module tb_dacrdbk;
  import dacrdbk_pkg::*;

  logic        i_mclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic        i_rd_req = 1'b0;
  logic [2:0]  i_rd_addr = 3'b000;
  logic        i_sdin = 1'b0;
  logic        o_rd_busy, o_rx_dv, o_rx_err, o_sclk, o_sdo, o_sync;
  logic [2:0]  o_rx_addr;
  logic [19:0] o_rx_data;

  dacrdbk dut (
    .i_mclk(i_mclk), .i_rst(i_rst), .i_en(i_en), .i_rd_req(i_rd_req),
    .i_rd_addr(i_rd_addr), .o_rd_busy(o_rd_busy), .o_rx_dv(o_rx_dv),
    .o_rx_addr(o_rx_addr), .o_rx_data(o_rx_data), .o_rx_err(o_rx_err),
    .o_sclk(o_sclk), .o_sdo(o_sdo), .i_sdin(i_sdin), .o_sync(o_sync)
  );

  always #5 i_mclk = ~i_mclk;

  int n_checks = 0;
  int n_errors = 0;

  // Device model and event monitor, evaluated on the falling mclk edge
  int          dv_cnt = 0;
  int          frames = 0;
  int          nb = 0;
  logic [19:0] dv_data = 20'h0;
  logic [2:0]  dv_addr = 3'b000;
  logic        dv_err = 1'b0;
  logic        dv_busy = 1'b0;
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b0;
  logic [23:0] cap = 24'h0;
  logic [23:0] dev_sh = 24'h0;
  logic [23:0] dev_resp = 24'h0;
  logic [23:0] last_cmd = 24'h0;
  logic [23:0] last_nop = 24'hFFFFFF;
  logic        rd_next = 1'b0;
  logic        drive = 1'b0;

  always @(negedge i_mclk) begin
    if (o_rx_dv === 1'b1) begin
      dv_cnt  = dv_cnt + 1;
      dv_data = o_rx_data;
      dv_addr = o_rx_addr;
      dv_err  = o_rx_err;
      dv_busy = o_rd_busy;
    end
    if (o_sync === 1'b1 && prev_sync === 1'b0) begin
      frames = frames + 1;
      cap    = 24'h0;
      nb     = 0;
      drive  = rd_next;
      dev_sh = dev_resp;
      i_sdin = drive ? dev_sh[23] : 1'b0;
    end else if (o_sync === 1'b1 && o_sclk === 1'b1 && prev_sclk === 1'b0) begin
      dev_sh = {dev_sh[22:0], 1'b0};
      i_sdin = drive ? dev_sh[23] : 1'b0;
    end
    if (o_sync === 1'b1 && o_sclk === 1'b0 && prev_sclk === 1'b1) begin
      cap = {cap[22:0], o_sdo};
      nb  = nb + 1;
    end
    if (o_sync === 1'b0 && prev_sync === 1'b1) begin
      if (nb == 24 && cap[23] == 1'b1) begin
        rd_next  = 1'b1;
        last_cmd = cap;
      end else begin
        rd_next = 1'b0;
        if (nb == 24) last_nop = cap;
      end
      drive  = 1'b0;
      i_sdin = 1'b0;
    end
    prev_sclk = o_sclk;
    prev_sync = o_sync;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge i_mclk);
    #2;
  endtask

  task automatic start_req(input logic [2:0] a);
    settle();
    i_rd_addr = a;
    i_rd_req  = 1'b1;
    settle();
    i_rd_req  = 1'b0;
  endtask

  task automatic wait_dv(input int d0, output int n, output int gap);
    bit seen;
    seen = 1'b0;
    n    = 1;
    gap  = 0;
    while (dv_cnt == d0 && n < 700) begin
      settle();
      n = n + 1;
      if (o_rd_busy === 1'b1) seen = 1'b1;
      else if (seen && dv_cnt == d0) gap = gap + 1;
    end
    if (dv_cnt == d0) chk("dv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames < target && k < 400) begin
      settle();
      k = k + 1;
    end
    if (frames < target) chk("frame_timeout", 32'(frames), 32'(target));
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [23:0] resp;
    logic [19:0] exp_data;
    logic [2:0]  exp_addr;
    logic        exp_err;
    logic [23:0] exp_frame;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    int d0, f0, n, gap;
    dev_resp = v.resp;
    d0 = dv_cnt;
    f0 = frames;
    start_req(v.addr);
    wait_dv(d0, n, gap);
    chk("rx_data", 32'(dv_data), 32'(v.exp_data));
    chk("rx_addr", 32'(dv_addr), 32'(v.exp_addr));
    chk("rx_err", 32'(dv_err), 32'(v.exp_err));
    chk("busy_at_dv", 32'(dv_busy), 32'd1);
    chk("busy_gap", 32'(gap), 32'd0);
    chk("latency_in_range", 32'((n >= 491) && (n <= 501)), 32'd1);
    repeat (15) settle();
    chk("dv_count", 32'(dv_cnt - d0), 32'd1);
    chk("frame_count", 32'(frames - f0), 32'd2);
    chk("cmd_frame", 32'(last_cmd), 32'(v.exp_frame));
    chk("nop_frame", 32'(last_nop), 32'd0);
    chk("busy_after", 32'(o_rd_busy), 32'd0);
    chk("sclk_idle", 32'(o_sclk), 32'd1);
    chk("rx_data_held", 32'(o_rx_data), 32'(v.exp_data));
  endtask

  initial begin
    int d0, f0, n, gap;
    logic [19:0] held;

    vecs[0] = '{DAC_CMD_CTRL, 24'hA0A5C3, 20'h0A5C3, 3'b010, 1'b0, 24'hA00000};
    vecs[1] = '{DAC_CMD_RG,   24'hB12345, 20'h12345, 3'b011, 1'b1, 24'h900000};
    vecs[2] = '{DAC_CMD_CLR,  24'h3FFFFF, 20'hFFFFF, 3'b011, 1'b1, 24'hB00000};
    vecs[3] = '{DAC_CMD_RG,   24'h900000, 20'h00000, 3'b001, 1'b0, 24'h900000};
    vecs[4] = '{DAC_CMD_CLR,  24'hBFFFFF, 20'hFFFFF, 3'b011, 1'b0, 24'hB00000};

    // reset state
    repeat (3) settle();
    chk("rst_sync", 32'(o_sync), 32'd0);
    chk("rst_sclk", 32'(o_sclk), 32'd1);
    chk("rst_busy", 32'(o_rd_busy), 32'd0);
    chk("rst_dv", 32'(o_rx_dv), 32'd0);
    chk("rst_sdo", 32'(o_sdo), 32'd0);
    chk("rst_data", 32'(o_rx_data), 32'd0);
    i_rst = 1'b0;
    repeat (7) settle();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // second request during CMD is ignored
    dev_resp = 24'hA0A5C3;
    d0 = dv_cnt;
    f0 = frames;
    start_req(DAC_CMD_CTRL);
    wait_frames(f0 + 1);
    repeat (30) settle();
    i_rd_addr = DAC_CMD_RG;
    i_rd_req  = 1'b1;
    settle();
    i_rd_req  = 1'b0;
    wait_dv(d0, n, gap);
    chk("ign_busy_gap", 32'(gap), 32'd0);
    chk("ign_data", 32'(dv_data), 32'h0A5C3);
    chk("ign_addr", 32'(dv_addr), 32'(3'b010));
    repeat (600) settle();
    chk("ign_dv_count", 32'(dv_cnt - d0), 32'd1);
    chk("ign_frames", 32'(frames - f0), 32'd2);

    // en dropped during CMD: frame completes, no read frame
    held = o_rx_data;
    d0 = dv_cnt;
    f0 = frames;
    start_req(DAC_CMD_CLR);
    wait_frames(f0 + 1);
    repeat (30) settle();
    chk("en_busy_mid", 32'(o_rd_busy), 32'd1);
    i_en = 1'b0;
    repeat (600) settle();
    chk("en_dv_count", 32'(dv_cnt - d0), 32'd0);
    chk("en_frames", 32'(frames - f0), 32'd1);
    chk("en_cmd_frame", 32'(last_cmd), 32'hB00000);
    chk("en_busy", 32'(o_rd_busy), 32'd0);
    chk("en_data_held", 32'(o_rx_data), 32'(held));
    i_en = 1'b1;
    repeat (5) settle();

    // reset during READ bit 10
    dev_resp = 24'h912345;
    d0 = dv_cnt;
    f0 = frames;
    start_req(DAC_CMD_RG);
    wait_frames(f0 + 2);
    repeat (103) settle();
    chk("abort_sync_before", 32'(o_sync), 32'd1);
    i_rst = 1'b1;
    settle();
    chk("abort_sync", 32'(o_sync), 32'd0);
    chk("abort_sclk", 32'(o_sclk), 32'd1);
    chk("abort_busy", 32'(o_rd_busy), 32'd0);
    settle();
    i_rst = 1'b0;
    repeat (600) settle();
    chk("abort_dv_count", 32'(dv_cnt - d0), 32'd0);
    chk("abort_frames", 32'(frames - f0), 32'd2);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
